// File: rtl/write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : write_buffer
// Purpose  : FIFO of write-through stores drained to memory, with read/write
//            arbitration that keeps reads ordered after same-block writes.
// Revision : 1.0 - initial release
// ============================================================================
module write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int OFF_W  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_valid,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic                     rd_done,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int C_PTR_W = $clog2(DEPTH);
    localparam int C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH     = C_CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0]  C_WORD_MASK = ~ADDR_W'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q [DEPTH];
    logic [ADDR_W-1:0]   addr_d [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [C_PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [C_CNT_W-1:0]  count_q, count_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                rd_done_q, rd_done_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic w_ack, w_push, w_pop, w_rd_req, w_hazard, w_go_write, w_go_read;

    // An ack only counts while a request is actually outstanding.
    assign w_ack    = mem_ack && mem_req_q;
    assign w_push   = wr_valid && (count_q < C_DEPTH);
    assign w_pop    = (state_q == S_WRITE) && w_ack;
    assign w_rd_req = rd_valid && !rd_done_q;

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i][ADDR_W-1:OFF_W] == rd_addr[ADDR_W-1:OFF_W])) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + C_PTR_W'(1);
        end
        if (w_push) begin
            addr_d[tail_q]  = wr_addr;
            data_d[tail_q]  = wr_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + C_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Decisions use only registered entries, so a store arriving this cycle
    // is naturally ordered after whatever is issued now.
    always_comb begin
        w_go_write = 1'b0;
        w_go_read  = 1'b0;
        if (state_q == S_IDLE) begin
            if (w_rd_req && w_hazard) begin
                w_go_write = 1'b1;
            end else if (w_rd_req) begin
                w_go_read = 1'b1;
            end else if (count_q != '0) begin
                w_go_write = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_done_d   = 1'b0;
        rd_data_d   = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (w_go_write) begin
                    state_d     = S_WRITE;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[head_q] & C_WORD_MASK;
                    mem_wdata_d = data_q[head_q];
                end else if (w_go_read) begin
                    state_d    = S_READ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = rd_addr & C_WORD_MASK;
                end
            end
            S_WRITE: begin
                if (w_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            S_READ: begin
                if (w_ack) begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                    rd_done_d = 1'b1;
                    rd_data_d = mem_rdata;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            valid_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_done_q   <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_done_q   <= rd_done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Entry payload needs no reset; valid_q qualifies it.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign wr_ready  = (count_q < C_DEPTH);
    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_done   = rd_done_q;
    assign rd_data   = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_buffer
// Purpose  : Self-checking bench for write_buffer against a program-order
//            memory model and a FIFO of expected memory writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int OFF_W  = 4;
    localparam int WORDS  = 1 << (ADDR_W - 2);

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    wr_valid, wr_ready, rd_valid, rd_done;
    logic [ADDR_W-1:0]       wr_addr, rd_addr, mem_addr;
    logic [DATA_W-1:0]       wr_data, rd_data, mem_wdata, mem_rdata;
    logic                    mem_req, mem_we, mem_ack;
    logic [$clog2(DEPTH):0]  count;
    logic                    empty;

    write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OFF_W(OFF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: stores in program order, memory as the bus left it.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } st_t;
    st_t               wq[$];
    int                model_cnt = 0;
    logic [DATA_W-1:0] mem    [WORDS];
    logic [DATA_W-1:0] shadow [WORDS];

    bit mon_en = 0, ack_en = 0, stray_en = 0;
    int dly_lo = 0, dly_hi = 0;
    logic              prev_req = 0, prev_we = 0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] prev_wdata = '0;
    logic              ack_eff, push_eff;

    // Monitor: one sample per cycle, just after the rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            ack_eff  = mem_ack && prev_req;
            push_eff = wr_valid && (model_cnt < DEPTH);
            if (ack_eff && prev_we) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    check("wr_addr", prev_addr, {wq[0].a[ADDR_W-1:2], 2'b00});
                    check("wr_data", prev_wdata, wq[0].d);
                    wq.delete(0);
                    model_cnt--;
                end
                mem[prev_addr[ADDR_W-1:2]] = prev_wdata;
            end
            if (ack_eff && !prev_we) begin
                check("rd_addr", prev_addr, {rd_addr[ADDR_W-1:2], 2'b00});
                check("rd_done", rd_done, 1);
                check("rd_data", rd_data, shadow[rd_addr[ADDR_W-1:2]]);
            end else begin
                check("rd_done_idle", rd_done, 0);
            end
            if (push_eff) begin
                wq.push_back({wr_addr, wr_data});
                shadow[wr_addr[ADDR_W-1:2]] = wr_data;
                model_cnt++;
            end
            check("count", count, model_cnt);
            check("empty", empty, model_cnt == 0);
            check("wr_ready", wr_ready, model_cnt < DEPTH);
            if (ack_eff) begin
                check("req_drop", mem_req, 0);
            end else if (prev_req) begin
                check("req_hold", {mem_req, mem_we, mem_addr, mem_wdata},
                      {1'b1, prev_we, prev_addr, prev_wdata});
            end
            if (mem_req) check("addr_align", mem_addr[1:0], 0);
            prev_req   = mem_req;
            prev_we    = mem_we;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
        end
    end

    // Memory responder: ack after a chosen delay, plus optional stray acks.
    int wcnt = 0, dly = 0;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && ack_en) begin
                if (wcnt == 0) dly = $urandom_range(dly_hi, dly_lo);
                if (wcnt >= dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr[ADDR_W-1:2]];
                    wcnt      = 0;
                end else begin
                    wcnt++;
                end
            end else if (!mem_req && stray_en && ($urandom_range(0, 3) == 0)) begin
                mem_ack   = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    task automatic apply_reset();
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_rd_done", rd_done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        wq.delete();
        model_cnt  = 0;
        prev_req   = 0;
        prev_we    = 0;
        prev_addr  = '0;
        prev_wdata = '0;
        for (int i = 0; i < WORDS; i++) shadow[i] = mem[i];
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        @(posedge clk);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!(empty && !mem_req) && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, n < 300, 1);
    endtask

    task automatic wait_rd_done(input string tag);
        int n = 0;
        while (!rd_done && n < 300) begin
            @(posedge clk);
            #2;
            n++;
        end
        check(tag, n < 300, 1);
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-OFF_W-1:0] blk;
        logic [OFF_W-1:0]        off;
        int k;
        k   = $urandom_range(0, 3);
        blk = (k == 3) ? '1 : (ADDR_W-OFF_W)'(k);
        off = OFF_W'($urandom);
        return {blk, off};
    endfunction

    bit rd_pend = 0;
    int rd_wait = 0;
    int diff    = 0;

    initial begin
        rst_n    = 1'b1;
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_addr  = '0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        #2;
        apply_reset();

        // Reset asserted mid-cycle with stores buffered and a write pending
        ack_en = 0;
        push(10'h100, 32'h1234);
        push(10'h108, 32'h5678);
        @(posedge clk);
        #3;
        apply_reset();

        // Single store, acked two cycles after the request
        ack_en = 1; dly_lo = 1; dly_hi = 1;
        push(10'h000, 32'h0000_00FF);
        #1;
        check("t2_req_early", mem_req, 0);
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t2_req", mem_req, 1);
        check("t2_we", mem_we, 1);
        check("t2_addr", mem_addr, 10'h000);
        check("t2_wdata", mem_wdata, 32'hFF);
        wait_empty("t2_drain");
        check("t2_mem", mem[0], 32'hFF);

        // Fill to capacity, overflow store dropped, drain in order
        ack_en = 0;
        for (int i = 0; i < DEPTH; i++) push(ADDR_W'(i * 4), DATA_W'(i + 1));
        #1;
        check("t3_full_count", count, DEPTH);
        check("t3_full_ready", wr_ready, 0);
        push(10'h010, 32'd5);
        #1;
        check("t3_ovf_count", count, DEPTH);
        @(negedge clk);
        wr_valid = 1'b0;
        ack_en = 1; dly_lo = 0; dly_hi = 0;
        wait_empty("t3_drain");
        for (int i = 0; i < DEPTH; i++) check("t3_mem", mem[i], DATA_W'(i + 1));
        check("t3_dropped", mem[4], 0);

        // Read hits a buffered same-block write: that write must drain first
        ack_en = 0;
        push(10'h040, 32'h55);
        push(10'h004, 32'hAB);
        @(negedge clk);
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 10'h004;
        repeat (2) @(negedge clk);
        ack_en = 1; dly_lo = 0; dly_hi = 2;
        wait_rd_done("t4_rd_wait");
        check("t4_rd_data", rd_data, 32'hAB);
        @(negedge clk);
        rd_valid = 1'b0;
        wait_empty("t4_drain");

        // Read to another block overtakes a buffered write
        ack_en = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h000; wr_data = 32'h11;
        rd_valid = 1'b1; rd_addr = 10'h200;
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t5_req", mem_req, 1);
        check("t5_we", mem_we, 0);
        check("t5_addr", mem_addr, 10'h200);
        ack_en = 1;
        wait_rd_done("t5_rd_wait");
        check("t5_rd_data", rd_data, 32'h0);
        @(negedge clk);
        rd_valid = 1'b0;
        wait_empty("t5_drain");
        check("t5_mem", mem[0], 32'h11);

        // Reset during an outstanding read discards it and the buffered write
        ack_en = 0;
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = 10'h300; wr_data = 32'h77;
        rd_valid = 1'b1; rd_addr = 10'h080;
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_req_before", mem_req, 1);
        #2;
        apply_reset();
        ack_en = 1;
        @(negedge clk);
        rd_valid = 1'b1;
        rd_addr  = 10'h040;
        wait_rd_done("t6_rd_wait");
        check("t6_rd_data", rd_data, 32'h55);
        @(negedge clk);
        rd_valid = 1'b0;
        wait_empty("t6_drain");
        check("t6_discarded", mem[10'h300 >> 2], 0);

        // Randomized traffic with variable ack delay and stray acks
        stray_en = 1; dly_lo = 0; dly_hi = 4;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            wr_valid = 1'b0;
            if (rd_pend) begin
                if (rd_done) begin
                    rd_valid = 1'b0;
                    rd_pend  = 0;
                end else begin
                    rd_wait++;
                    if (rd_wait > 300) begin
                        check("rnd_rd_timeout", 0, 1);
                        break;
                    end
                end
            end else if ($urandom_range(0, 5) == 0) begin
                rd_valid = 1'b1;
                rd_addr  = rand_addr();
                rd_pend  = 1;
                rd_wait  = 0;
            end else if ($urandom_range(0, 1) == 1) begin
                wr_valid = 1'b1;
                wr_addr  = rand_addr();
                wr_data  = $urandom;
            end
        end
        @(negedge clk);
        wr_valid = 1'b0;
        if (rd_pend) begin
            wait_rd_done("rnd_last_rd");
            @(negedge clk);
            rd_valid = 1'b0;
        end
        stray_en = 0;
        wait_empty("rnd_drain");
        repeat (2) @(posedge clk);
        for (int i = 0; i < WORDS; i++) if (mem[i] !== shadow[i]) diff++;
        check("mem_final", diff, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/write_buffer.md
Name: write_buffer

Overview:
- Write buffer between the 2-way write-through cache and main memory.
- Queues the cache's write-through stores in a FIFO and drains them to memory one word at a time.
- Arbitrates cache miss-fill reads against pending writes, and orders them so a read never returns data older than a buffered write to the same block.
- All memory traffic uses a req/ack handshake.

Parameters:
DEPTH, 4, number of buffered write entries (power of 2, >=2)
ADDR_W, 10, byte address width
DATA_W, 32, word width
OFF_W, 4, block offset bits (16-byte block); hazard compare uses addr[ADDR_W-1:OFF_W]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  cache presents write-through store
wr_ready  out  1  buffer can accept store (= count < DEPTH)
wr_addr  in  ADDR_W  store byte address
wr_data  in  DATA_W  store data
rd_valid  in  1  cache requests one word from memory; held with rd_addr until rd_done
rd_addr  in  ADDR_W  read byte address
rd_done  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATA_W  returned word
mem_req  out  1  memory request, held until ack
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_W  word-aligned address (bits [1:0] forced 0)
mem_wdata  out  DATA_W  write data
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_ack  in  1  memory completes request
count  out  clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low):
  - head/tail/count = 0, state IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata, rd_done, rd_data = 0; empty = 1.
  - Reset mid-transaction aborts it and discards all buffered writes.
- Push: wr_valid && wr_ready at a rising edge stores {wr_addr, wr_data} at tail, tail++ mod DEPTH.
  - wr_valid while full: no effect.
  - Push and pop in the same cycle: count unchanged.
- States: IDLE, WRITE, READ. All memory-side outputs are registered.
- IDLE, evaluated each cycle using registered entries only, ignoring rd_valid while rd_done is high. First match wins:
  1. rd_valid && some valid entry matches rd_addr block → WRITE on head (drain until no match).
  2. rd_valid → READ.
  3. count > 0 → WRITE.
  4. Otherwise stay IDLE.
- Ordering and priority:
  - Reads have priority over non-conflicting writes.
  - A write pushed in the same cycle a read is issued is ordered after that read.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=head addr & ~3, mem_wdata=head data, all stable until mem_ack.
  - On mem_ack: pop head, mem_req=0 next cycle, → IDLE.
- READ:
  - mem_req=1, mem_we=0, mem_addr=rd_addr & ~3.
  - On mem_ack: rd_data <= mem_rdata, rd_done=1 next cycle, mem_req=0, → IDLE.
- Latency:
  - A store pushed at edge N can raise mem_req at edge N+1 at the earliest.
  - rd_done rises one edge after mem_ack.
  - Minimum 1 idle cycle (mem_req low) between consecutive requests.
- mem_ack while mem_req is low is ignored.
- Pointer wrap: head and tail wrap modulo DEPTH; count distinguishes full from empty.
- rd_data holds its last value until the next read completes.

Test Plan:
1. Reset: drive stimulus, pull rst_n low asynchronously mid-cycle → all outputs 0 immediately, empty=1, count=0.
2. Single store: push addr 0x000 data 0x000000FF, ack 2 cycles after mem_req → mem_req=1, mem_we=1, mem_addr=0x000, mem_wdata=0xFF; after ack, empty=1; memory word 0 = 0xFF.
3. Full/overflow: hold mem_ack=0, push 0x000..0x00C with data 1..4 → count=4, wr_ready=0; 5th push (0x010, 5) dropped; then ack each → memory writes in order 1,2,3,4, final count=0.
4. RAW hazard: buffer write 0x004=0xAB with ack held low, assert rd_valid rd_addr=0x004 → the write is issued first, then the read; rd_done pulses with rd_data=0xAB.
5. Read priority: buffer write 0x000=0x11, assert read 0x200 (different block) → first mem_req is read (mem_we=0, addr 0x200), the write follows afterwards.
6. Reset mid-READ: rst_n low while mem_req=1 → mem_req=0, rd_done stays 0, buffer empty; after release, a new read completes normally.
